// File: rtl/multicycle_sequencer_if.sv
// Handshake/strobe bundle between the multicycle sequencer and the rest of the core.
// The sequencer side uses the master modport: it receives decoded flags and memory
// acks, and drives phase strobes, memory requests, status and performance counters.
interface multicycle_sequencer_if #(
  parameter int unsigned PERF_WIDTH = 32
) ();

  // Decoded instruction flags and control inputs
  logic start;
  logic clr;
  logic branchFlag;
  logic memWrite;
  logic memToReg;
  logic regWrite;
  logic branchTaken;
  logic haltInstr;
  logic imemAck;
  logic dmemAck;

  // Phase strobes and memory requests
  logic imemReq;
  logic irWrite;
  logic aluEn;
  logic dmemReq;
  logic dmemWe;
  logic regWriteEn;
  logic pcWrite;
  logic pcSrc;

  // Status and performance
  logic [2:0]            state;
  logic                  busy;
  logic                  halted;
  logic                  busErr;
  logic [PERF_WIDTH-1:0] retiredCount;
  logic [PERF_WIDTH-1:0] waitCount;

  modport master (
    input  start, clr, branchFlag, memWrite, memToReg, regWrite, branchTaken, haltInstr,
           imemAck, dmemAck,
    output imemReq, irWrite, aluEn, dmemReq, dmemWe, regWriteEn, pcWrite, pcSrc,
           state, busy, halted, busErr, retiredCount, waitCount
  );

  modport slave (
    output start, clr, branchFlag, memWrite, memToReg, regWrite, branchTaken, haltInstr,
           imemAck, dmemAck,
    input  imemReq, irWrite, aluEn, dmemReq, dmemWe, regWriteEn, pcWrite, pcSrc,
           state, busy, halted, busErr, retiredCount, waitCount
  );

endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with memory ack timeout
// and halt detection. Strobes are combinational decodes of the state and acks.
// Optional macro SEQ_PERF_CNT_EN builds saturating retired/wait counters; without it
// both counter outputs are tied to zero.
module multicycle_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned PERF_WIDTH     = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  multicycle_sequencer_if.master seq_io
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StHalt   = 3'd6
  } state_e;

  // A zero timeout disables the check; keep a 1-bit counter so widths stay legal.
  localparam bit          TimeoutEn = (TIMEOUT_CYCLES != 0);
  localparam int unsigned WaitW     = TimeoutEn ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WaitW-1:0] WaitMax = WaitW'(TimeoutEn ? TIMEOUT_CYCLES - 1 : 0);

  state_e           state_q, state_d;
  logic             bus_err_q, bus_err_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;

  logic imem_req, ir_write, alu_en, dmem_req, dmem_we, reg_write_en, pc_write, pc_src;
  logic mem_wait;     // FETCH/MEM cycle without an ack
  logic timeout_hit;  // this non-ack cycle is the last one allowed

  assign timeout_hit = TimeoutEn && (wait_cnt_q == WaitMax);

  // Next-state, strobe decode and wait counter update
  always_comb begin
    state_d      = state_q;
    bus_err_d    = bus_err_q;
    wait_cnt_d   = wait_cnt_q;
    imem_req     = 1'b0;
    ir_write     = 1'b0;
    alu_en       = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    reg_write_en = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    mem_wait     = 1'b0;

    case (state_q)
      StIdle: begin
        if (seq_io.start) state_d = StFetch;
      end
      StFetch: begin
        imem_req = 1'b1;
        if (seq_io.imemAck) begin
          ir_write = 1'b1;
          state_d  = StDecode;
        end else begin
          mem_wait = 1'b1;
          if (timeout_hit) begin
            state_d   = StHalt;
            bus_err_d = 1'b1;
          end
        end
      end
      StDecode: begin
        state_d = seq_io.haltInstr ? StHalt : StExec;
      end
      StExec: begin
        alu_en = 1'b1;
        if (seq_io.branchFlag) begin
          pc_write = 1'b1;
          pc_src   = seq_io.branchTaken;
          state_d  = StFetch;
        end else if (seq_io.memWrite || seq_io.memToReg) begin
          state_d = StMem;
        end else if (seq_io.regWrite) begin
          state_d = StWb;
        end else begin
          pc_write = 1'b1;
          state_d  = StFetch;
        end
      end
      StMem: begin
        dmem_req = 1'b1;
        dmem_we  = seq_io.memWrite;
        if (seq_io.dmemAck) begin
          // A set store flag wins over load when both are decoded.
          if (seq_io.memToReg && !seq_io.memWrite) begin
            state_d = StWb;
          end else begin
            pc_write = 1'b1;
            state_d  = StFetch;
          end
        end else begin
          mem_wait = 1'b1;
          if (timeout_hit) begin
            state_d   = StHalt;
            bus_err_d = 1'b1;
          end
        end
      end
      StWb: begin
        reg_write_en = 1'b1;
        pc_write     = 1'b1;
        state_d      = StFetch;
      end
      StHalt: begin
        if (seq_io.clr) begin
          state_d   = StIdle;
          bus_err_d = 1'b0;
        end
      end
      default: begin
        state_d   = StHalt;
        bus_err_d = 1'b1;
      end
    endcase

    if (state_d != state_q) begin
      wait_cnt_d = '0;
    end else if (mem_wait && TimeoutEn) begin
      wait_cnt_d = wait_cnt_q + WaitW'(1);
    end
  end

  // State, sticky error and wait counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      bus_err_q  <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      bus_err_q  <= bus_err_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

`ifdef SEQ_PERF_CNT_EN
  logic [PERF_WIDTH-1:0] retired_q, waits_q;

  // Saturating performance counters; only reset clears them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q <= '0;
      waits_q   <= '0;
    end else begin
      if (pc_write && !(&retired_q)) retired_q <= retired_q + PERF_WIDTH'(1);
      if (mem_wait && !(&waits_q))   waits_q   <= waits_q + PERF_WIDTH'(1);
    end
  end

  assign seq_io.retiredCount = retired_q;
  assign seq_io.waitCount    = waits_q;
`else
  assign seq_io.retiredCount = {PERF_WIDTH{1'b0}};
  assign seq_io.waitCount    = {PERF_WIDTH{1'b0}};
`endif

  assign seq_io.imemReq    = imem_req;
  assign seq_io.irWrite    = ir_write;
  assign seq_io.aluEn      = alu_en;
  assign seq_io.dmemReq    = dmem_req;
  assign seq_io.dmemWe     = dmem_we;
  assign seq_io.regWriteEn = reg_write_en;
  assign seq_io.pcWrite    = pc_write;
  assign seq_io.pcSrc      = pc_src;
  assign seq_io.state      = state_q;
  assign seq_io.busy       = (state_q != StIdle) && (state_q != StHalt);
  assign seq_io.halted     = (state_q == StHalt);
  assign seq_io.busErr     = bus_err_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer. Each instruction is expanded by a
// transaction-level model into its expected per-cycle phase list, ack schedule,
// retire/error outcome and counter totals, which are then compared with the DUT.
module tb_multicycle_sequencer;

  localparam int unsigned TO = 4;
  localparam int unsigned PW = 32;
`ifdef SEQ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk;
  logic rst_n;

  multicycle_sequencer_if #(.PERF_WIDTH(PW)) sif ();

  multicycle_sequencer #(
    .TIMEOUT_CYCLES(TO),
    .PERF_WIDTH    (PW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .seq_io(sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;
  int exp_ret;   // retired instructions since reset
  int exp_wait;  // non-ack memory cycles since reset
  bit exp_err;
  int exp_end;   // phase expected after the last modelled instruction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_idle_inputs();
    sif.start = 0; sif.clr = 0; sif.branchFlag = 0; sif.memWrite = 0; sif.memToReg = 0;
    sif.regWrite = 0; sif.branchTaken = 0; sif.haltInstr = 0; sif.imemAck = 0;
    sif.dmemAck = 0;
  endtask

  // Reset and leave the bench in the low clock phase with the model cleared.
  task automatic do_reset();
    drive_idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_ret = 0; exp_wait = 0; exp_err = 0; exp_end = 0;
  endtask

  task automatic kick();
    sif.start = 1;
    @(negedge clk);
    sif.start = 0;
    exp_end = 1;
  endtask

  task automatic clear();
    sif.clr = 1;
    @(negedge clk);
    sif.clr = 0;
    exp_err = 0;
    exp_end = 0;
  endtask

  // Expected phase codes: 1 fetch, 2 decode, 3 exec, 4 mem, 5 writeback, 6 halt.
  // fdly/mdly are non-ack cycles before the ack; a delay >= TO means no ack at all.
  task automatic run_instr(input bit br, input bit mw, input bit mr, input bit rw,
                           input bit bt, input bit hl, input int fdly, input int mdly);
    int st_q[$];
    bit ia_q[$];
    bit da_q[$];
    bit retire;
    bit e_rwe;
    bit e_src;
    int last;
    sif.branchFlag = br; sif.memWrite = mw; sif.memToReg = mr; sif.regWrite = rw;
    sif.branchTaken = bt; sif.haltInstr = hl;
    retire = 0; e_rwe = 0; e_src = 0; exp_end = 1;

    for (int i = 0; i < fdly && i < int'(TO); i++) begin
      st_q.push_back(1); ia_q.push_back(0); da_q.push_back(0); exp_wait++;
    end
    if (fdly >= int'(TO)) begin
      exp_end = 6; exp_err = 1;
    end else begin
      st_q.push_back(1); ia_q.push_back(1); da_q.push_back(0);
      st_q.push_back(2); ia_q.push_back(0); da_q.push_back(0);
      if (hl) begin
        exp_end = 6;
      end else begin
        st_q.push_back(3); ia_q.push_back(0); da_q.push_back(0);
        if (br) begin
          retire = 1; e_src = bt;
        end else if (mw || mr) begin
          for (int i = 0; i < mdly && i < int'(TO); i++) begin
            st_q.push_back(4); ia_q.push_back(0); da_q.push_back(0); exp_wait++;
          end
          if (mdly >= int'(TO)) begin
            exp_end = 6; exp_err = 1;
          end else begin
            st_q.push_back(4); ia_q.push_back(0); da_q.push_back(1);
            if (mr && !mw) begin
              st_q.push_back(5); ia_q.push_back(0); da_q.push_back(0); e_rwe = 1;
            end
            retire = 1;
          end
        end else begin
          if (rw) begin
            st_q.push_back(5); ia_q.push_back(0); da_q.push_back(0); e_rwe = 1;
          end
          retire = 1;
        end
      end
    end
    if (retire) exp_ret++;
    last = st_q.size() - 1;

    foreach (st_q[k]) begin
      sif.imemAck = ia_q[k];
      sif.dmemAck = da_q[k];
      #1;
      n_chk++;
      if (sif.state !== 3'(st_q[k])) begin
        n_fail++;
        $display("FAIL phase[%0d]: state got %0d, expected %0d", k, sif.state, st_q[k]);
      end
      n_chk++;
      if (sif.imemReq !== (st_q[k] == 1)) begin
        n_fail++;
        $display("FAIL imemReq[%0d]: got %b, expected %b", k, sif.imemReq, st_q[k] == 1);
      end
      n_chk++;
      if (sif.irWrite !== ia_q[k]) begin
        n_fail++;
        $display("FAIL irWrite[%0d]: got %b, expected %b", k, sif.irWrite, ia_q[k]);
      end
      n_chk++;
      if (sif.aluEn !== (st_q[k] == 3)) begin
        n_fail++;
        $display("FAIL aluEn[%0d]: got %b, expected %b", k, sif.aluEn, st_q[k] == 3);
      end
      n_chk++;
      if (sif.dmemReq !== (st_q[k] == 4)) begin
        n_fail++;
        $display("FAIL dmemReq[%0d]: got %b, expected %b", k, sif.dmemReq, st_q[k] == 4);
      end
      n_chk++;
      if (sif.dmemWe !== (st_q[k] == 4 && mw)) begin
        n_fail++;
        $display("FAIL dmemWe[%0d]: got %b, expected %b", k, sif.dmemWe, st_q[k] == 4 && mw);
      end
      n_chk++;
      if (sif.regWriteEn !== (e_rwe && st_q[k] == 5)) begin
        n_fail++;
        $display("FAIL regWriteEn[%0d]: got %b, expected %b", k, sif.regWriteEn,
                 e_rwe && st_q[k] == 5);
      end
      n_chk++;
      if (sif.pcWrite !== (retire && k == last)) begin
        n_fail++;
        $display("FAIL pcWrite[%0d]: got %b, expected %b", k, sif.pcWrite, retire && k == last);
      end
      if (retire && k == last) begin
        n_chk++;
        if (sif.pcSrc !== e_src) begin
          n_fail++;
          $display("FAIL pcSrc[%0d]: got %b, expected %b", k, sif.pcSrc, e_src);
        end
      end
      @(negedge clk);
    end

    sif.imemAck = 0;
    sif.dmemAck = 0;
    #1;
    n_chk++;
    if (sif.state !== 3'(exp_end)) begin
      n_fail++;
      $display("FAIL end_state: got %0d, expected %0d", sif.state, exp_end);
    end
    n_chk++;
    if (sif.busErr !== exp_err) begin
      n_fail++;
      $display("FAIL busErr: got %b, expected %b", sif.busErr, exp_err);
    end
    n_chk++;
    if (sif.halted !== (exp_end == 6) || sif.busy !== (exp_end != 6)) begin
      n_fail++;
      $display("FAIL busy_halted: got busy=%b halted=%b, expected halted=%b",
               sif.busy, sif.halted, exp_end == 6);
    end
    n_chk++;
    if (sif.retiredCount !== (PERF ? PW'(exp_ret) : PW'(0))) begin
      n_fail++;
      $display("FAIL retiredCount: got %0d, expected %0d", sif.retiredCount,
               PERF ? exp_ret : 0);
    end
    n_chk++;
    if (sif.waitCount !== (PERF ? PW'(exp_wait) : PW'(0))) begin
      n_fail++;
      $display("FAIL waitCount: got %0d, expected %0d", sif.waitCount, PERF ? exp_wait : 0);
    end
  endtask

  task automatic test_reset();
    drive_idle_inputs();
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (sif.state !== 3'd0 || sif.busy !== 1'b0 || sif.halted !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got state=%0d busy=%b halted=%b, expected 0/0/0",
               sif.state, sif.busy, sif.halted);
    end
    n_chk++;
    if (sif.busErr !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busErr: got %b, expected 0", sif.busErr);
    end
    n_chk++;
    if ({sif.imemReq, sif.irWrite, sif.aluEn, sif.dmemReq, sif.dmemWe, sif.regWriteEn,
         sif.pcWrite, sif.pcSrc} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b, expected 00000000", {sif.imemReq, sif.irWrite,
               sif.aluEn, sif.dmemReq, sif.dmemWe, sif.regWriteEn, sif.pcWrite, sif.pcSrc});
    end
    n_chk++;
    if (sif.retiredCount !== '0 || sif.waitCount !== '0) begin
      n_fail++;
      $display("FAIL reset_counters: got %0d/%0d, expected 0/0",
               sif.retiredCount, sif.waitCount);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_ret = 0; exp_wait = 0; exp_err = 0; exp_end = 0;
    @(negedge clk);
    #1;
    n_chk++;
    if (sif.state !== 3'd0) begin
      n_fail++;
      $display("FAIL idle_hold: got %0d, expected 0", sif.state);
    end
    kick();
    #1;
    n_chk++;
    if (sif.state !== 3'd1) begin
      n_fail++;
      $display("FAIL start_to_fetch: got %0d, expected 1", sif.state);
    end
  endtask

  task automatic test_alu();
    do_reset(); kick();
    run_instr(0, 0, 0, 1, 0, 0, 2, 0);
    run_instr(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_load_store();
    do_reset(); kick();
    run_instr(0, 0, 1, 1, 0, 0, 0, 0);
    run_instr(0, 1, 1, 0, 0, 0, 0, 1);
    run_instr(0, 1, 0, 1, 0, 0, 1, 2);
  endtask

  task automatic test_branch();
    do_reset(); kick();
    run_instr(1, 0, 0, 0, 1, 0, 0, 0);
    run_instr(1, 0, 0, 0, 0, 0, 1, 0);
    run_instr(1, 1, 1, 1, 1, 0, 0, 0);
  endtask

  task automatic test_timeout();
    do_reset(); kick();
    run_instr(0, 0, 0, 1, 0, 0, int'(TO), 0);
    clear();
    #1;
    n_chk++;
    if (sif.state !== 3'd0 || sif.busErr !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_after_timeout: got state=%0d busErr=%b, expected 0/0",
               sif.state, sif.busErr);
    end
    kick();
    run_instr(0, 0, 0, 1, 0, 0, int'(TO) - 1, 0);
    run_instr(0, 0, 1, 0, 0, 0, 0, int'(TO) - 1);
    run_instr(0, 0, 1, 0, 0, 0, 0, int'(TO));
  endtask

  task automatic test_halt();
    do_reset(); kick();
    run_instr(0, 0, 0, 1, 0, 1, 1, 0);
    sif.start = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      n_chk++;
      if (sif.state !== 3'd6 || sif.halted !== 1'b1) begin
        n_fail++;
        $display("FAIL halt_hold[%0d]: got state=%0d halted=%b, expected 6/1",
                 i, sif.state, sif.halted);
      end
      n_chk++;
      if ({sif.imemReq, sif.irWrite, sif.aluEn, sif.dmemReq, sif.dmemWe, sif.regWriteEn,
           sif.pcWrite} !== 7'h00) begin
        n_fail++;
        $display("FAIL halt_strobes[%0d]: got nonzero strobes, expected 0", i);
      end
    end
    sif.clr = 1;
    @(negedge clk);
    sif.clr = 0;
    sif.start = 0;
    #1;
    n_chk++;
    if (sif.state !== 3'd0 || sif.busErr !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_clr: got state=%0d busErr=%b, expected 0/0", sif.state, sif.busErr);
    end
  endtask

  task automatic test_async_reset();
    do_reset(); kick();
    sif.memWrite = 1;
    sif.imemAck = 1;
    @(negedge clk);
    sif.imemAck = 0;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_chk++;
    if (sif.dmemReq !== 1'b1 || sif.state !== 3'd4) begin
      n_fail++;
      $display("FAIL pre_reset_mem: got state=%0d dmemReq=%b, expected 4/1",
               sif.state, sif.dmemReq);
    end
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (sif.dmemReq !== 1'b0 || sif.busy !== 1'b0 || sif.state !== 3'd0) begin
      n_fail++;
      $display("FAIL async_reset: got state=%0d dmemReq=%b busy=%b, expected 0/0/0",
               sif.state, sif.dmemReq, sif.busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive_idle_inputs();
    @(negedge clk);
    #1;
    n_chk++;
    if (sif.state !== 3'd0 || sif.retiredCount !== '0 || sif.waitCount !== '0) begin
      n_fail++;
      $display("FAIL post_reset: got state=%0d counts=%0d/%0d, expected 0/0/0",
               sif.state, sif.retiredCount, sif.waitCount);
    end
  endtask

  task automatic test_random();
    bit br, mw, mr, rw, bt, hl;
    int fd, md;
    do_reset(); kick();
    for (int n = 0; n < 60; n++) begin
      br = 1'($urandom_range(0, 3) == 0);
      mw = 1'($urandom_range(0, 1));
      mr = 1'($urandom_range(0, 1));
      rw = 1'($urandom_range(0, 1));
      bt = 1'($urandom_range(0, 1));
      hl = 1'($urandom_range(0, 11) == 0);
      fd = ($urandom_range(0, 9) == 0) ? int'(TO) : int'($urandom_range(0, 3));
      md = ($urandom_range(0, 9) == 0) ? int'(TO) : int'($urandom_range(0, 3));
      run_instr(br, mw, mr, rw, bt, hl, fd, md);
      if (exp_end == 6) begin
        clear();
        kick();
      end
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b1;
    drive_idle_inputs();
    test_reset();
    test_alu();
    test_load_store();
    test_branch();
    test_timeout();
    test_halt();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle instruction sequencer for the core: steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Consumes the decoded flags from controlUnit (branchFlag, memWrite, memToReg, regWrite) plus a branch-condition result.
- Drives per-phase enable strobes to PC, IR, ALU, register file and the instruction/data memory req/ack handshakes.
- Detects memory timeouts and halt instructions.

Parameters:
- TIMEOUT_CYCLES, 16: maximum wait cycles for an ack in FETCH or MEM; 0 disables the timeout.
- PERF_WIDTH, 32: width of the performance counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  leave IDLE; ignored in all other states
- clr  in  1  leave HALT to IDLE and clear busErr
- branchFlag  in  1  decoded branch
- memWrite  in  1  decoded store
- memToReg  in  1  decoded load
- regWrite  in  1  decoded register write
- branchTaken  in  1  branch condition true (valid in EXEC)
- haltInstr  in  1  decoded halt (valid in DECODE)
- imemAck  in  1  instruction memory ack
- dmemAck  in  1  data memory ack
- imemReq  out  1  instruction fetch request
- irWrite  out  1  latch instruction register
- aluEn  out  1  ALU operands/result valid
- dmemReq  out  1  data memory request
- dmemWe  out  1  data memory write enable
- regWriteEn  out  1  register file write strobe
- pcWrite  out  1  PC update strobe (instruction retire)
- pcSrc  out  1  0 = PC+4, 1 = branch target
- state  out  3  current state encoding
- busy  out  1  state is neither IDLE nor HALT
- halted  out  1  state is HALT
- busErr  out  1  sticky timeout error
- retiredCount  out  PERF_WIDTH  retired instructions
- waitCount  out  PERF_WIDTH  memory wait cycles

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6. Encoding 7 is illegal and goes to HALT with busErr=1.
- Strobes are combinational decodes of state plus the ack inputs. state, busErr, counters and waitCnt are registers.
- Reset (async, mid-operation included): state=IDLE, busErr=0, waitCnt=0, counters=0. All strobes are therefore 0 immediately.
- IDLE: start=1 -> FETCH.
- FETCH: imemReq=1.
  - imemAck=1 -> irWrite=1 in the same cycle, then DECODE.
  - Otherwise waitCnt increments.
- DECODE: exactly 1 cycle. haltInstr=1 -> HALT (no retire); else -> EXEC.
- EXEC: aluEn=1. Priority is branch > memory > register.
  - branchFlag=1: pcWrite=1, pcSrc=branchTaken, then FETCH. regWrite is ignored.
  - Else memWrite|memToReg: go to MEM.
  - Else regWrite: go to WB.
  - Else: pcWrite=1, pcSrc=0, then FETCH.
- MEM: dmemReq=1, dmemWe=memWrite.
  - On dmemAck with memToReg=1 and memWrite=0 -> WB.
  - On dmemAck otherwise (store, or both flags set = store) -> pcWrite=1, pcSrc=0, then FETCH.
- WB: regWriteEn=1, pcWrite=1, pcSrc=0; exactly 1 cycle; then FETCH.
- Timeout: waitCnt clears on every state change and counts non-ack cycles in FETCH or MEM.
  - An ack is accepted in any of the first TIMEOUT_CYCLES cycles of the state.
  - If waitCnt==TIMEOUT_CYCLES-1 and there is no ack: go to HALT, busErr=1, no strobe for that instruction.
  - waitCnt width is clog2(TIMEOUT_CYCLES+1).
- HALT: all strobes 0.
  - clr=1 -> IDLE and busErr=0. start is ignored.
  - If clr and start are both high in HALT, go to IDLE only.
- Instruction latency with zero-wait memory: ALU 4 cycles, load 5, store 4, branch 3.

Optional Feature:
- Macro SEQ_PERF_CNT_EN.
- Defined:
  - retiredCount increments on every cycle with pcWrite=1.
  - waitCount increments on every FETCH/MEM cycle without ack.
  - Both counters saturate at all-ones, reset to 0, and are not cleared by clr.
- Undefined: both ports remain present and are tied to 0; no counter flops are built.

Test Plan:
1. ALU op (regWrite=1), start, imemAck on the 3rd FETCH cycle -> states 1,1,1,2,3,5,1. regWriteEn and pcWrite high only in WB, pcSrc=0. retiredCount=1 (with macro).
2. Load (memToReg=1), dmemAck on 1st MEM cycle -> 1,2,3,4,5,1. dmemWe=0; regWriteEn=1 one cycle. Store with memWrite=memToReg=1 -> dmemWe=1, MEM->FETCH, no WB, pcWrite=1.
3. Branch with branchTaken=1 -> pcWrite=1 and pcSrc=1 in EXEC, next state FETCH. With branchTaken=0 -> pcSrc=0. regWrite=1 together with branch -> regWriteEn never asserts.
4. TIMEOUT_CYCLES=4, imemAck held 0 -> 4 FETCH cycles then HALT, busErr=1, halted=1, waitCount=4. Repeat with ack on 4th cycle -> DECODE, busErr=0.
5. haltInstr=1 in DECODE -> HALT, no pcWrite. start held high stays in HALT. clr=1 -> IDLE with busErr=0.
6. rst_n low mid-MEM with dmemReq=1 -> dmemReq, busy, state read 0 before the next clk edge. After release: IDLE, counters 0.
